// File: rtl/lightsout_pkg.sv
// lightsout_pkg: shared state encoding, command opcodes and board constants for the Lights Out controller
package lightsout_pkg;

    localparam int CELLS = 9;
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEED = 3'd1,
        ST_PLAY = 3'd2,
        ST_WAIT = 3'd3,
        ST_WIN  = 3'd4
    } state_t;

    localparam logic OP_TOGGLE = 1'b0;
    localparam logic OP_LOAD   = 1'b1;

    // An all-dark seed would be an instant win, so a single centre light is loaded instead
    localparam logic [CELLS-1:0] SEED_FALLBACK = 9'h010;

    // One-hot board mask for a cell index
    function automatic logic [CELLS-1:0] cell_mask(input logic [IDX_W-1:0] idx);
        cell_mask = {{(CELLS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/lightsout_prio_arb.sv
// lightsout_prio_arb: combinational lowest-index-first selection over the pending cell set
module lightsout_prio_arb
    import lightsout_pkg::*;
(
    input  logic [CELLS-1:0] req,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        grant = '0;
        for (int i = CELLS - 1; i >= 0; i--)
            if (req[i]) grant = IDX_W'(i);
    end

    assign any = |req;

endmodule

// File: rtl/lightsout_game_ctrl.sv
// lightsout_game_ctrl: Lights Out game FSM issuing LOAD/TOGGLE commands to the board datapath.
// Optional macro LIGHTSOUT_MOVE_LIMIT_EN adds parameter MOVE_LIMIT and the lost-game path.
module lightsout_game_ctrl
    import lightsout_pkg::*;
#(
    parameter int WIN_HOLD = 1024,
    parameter int MOVE_W   = 8
`ifdef LIGHTSOUT_MOVE_LIMIT_EN
    ,
    parameter int MOVE_LIMIT = 50
`endif
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [CELLS-1:0]  press,
    input  logic [CELLS-1:0]  board,
    input  logic [CELLS-1:0]  rand_in,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_op,
    output logic [IDX_W-1:0]  cmd_idx,
    output logic [CELLS-1:0]  cmd_data,
    output logic [2:0]        state,
    output logic [MOVE_W-1:0] moves,
    output logic              win,
    output logic              lost
);

    localparam int CNT_W = $clog2(WIN_HOLD + 1);

    state_t           st;
    logic [CELLS-1:0] pending;
    logic [CELLS-1:0] pend_next;
    logic [IDX_W-1:0] grant;
    logic             grant_any;
    logic [CNT_W-1:0] win_cnt;

    // Arbitration sees this cycle's presses so a press is issued on the very next cycle
    assign pend_next = pending | press;
    assign state     = st;

    lightsout_prio_arb u_arb (
        .req   (pend_next),
        .grant (grant),
        .any   (grant_any)
    );

`ifndef LIGHTSOUT_MOVE_LIMIT_EN
    assign lost = 1'b0;
`endif

    // Game sequencing with all command and status outputs registered
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            st        <= ST_IDLE;
            pending   <= '0;
            moves     <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_TOGGLE;
            cmd_idx   <= '0;
            cmd_data  <= '0;
            win       <= 1'b0;
            win_cnt   <= '0;
`ifdef LIGHTSOUT_MOVE_LIMIT_EN
            lost      <= 1'b0;
`endif
        end else begin
            case (st)
                ST_IDLE: begin
                    if (|press) begin
                        st        <= ST_SEED;
                        pending   <= '0;
                        moves     <= '0;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_LOAD;
                        cmd_data  <= (rand_in == '0) ? SEED_FALLBACK : rand_in;
`ifdef LIGHTSOUT_MOVE_LIMIT_EN
                        lost      <= 1'b0;
`endif
                    end
                end
                ST_SEED: begin
                    pending <= pend_next;
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        st        <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (cmd_valid && cmd_ready) begin
                        pending   <= (pending & ~cell_mask(cmd_idx)) | press;
                        moves     <= (&moves) ? moves : moves + 1'b1;
                        cmd_valid <= 1'b0;
                        st        <= ST_WAIT;
                    end else if (cmd_valid) begin
                        pending <= pend_next;
                    end else begin
                        pending <= pend_next;
                        if (grant_any) begin
                            cmd_valid <= 1'b1;
                            cmd_op    <= OP_TOGGLE;
                            cmd_idx   <= grant;
                        end
                    end
                end
                ST_WAIT: begin
                    pending <= pend_next;
                    if (board == '0) begin
                        st      <= ST_WIN;
                        win     <= 1'b1;
                        win_cnt <= '0;
                        pending <= '0;
`ifdef LIGHTSOUT_MOVE_LIMIT_EN
                    end else if (moves == MOVE_W'(MOVE_LIMIT)) begin
                        st   <= ST_IDLE;
                        lost <= 1'b1;
`endif
                    end else begin
                        st <= ST_PLAY;
                    end
                end
                ST_WIN: begin
                    pending <= '0;
                    if (win_cnt == CNT_W'(WIN_HOLD - 1)) begin
                        st      <= ST_IDLE;
                        win     <= 1'b0;
                        win_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lightsout_game_ctrl.sv
// tb_lightsout_game_ctrl: directed and randomized self-checking bench for lightsout_game_ctrl
module tb_lightsout_game_ctrl;
    import lightsout_pkg::*;

    localparam int HOLD = 8;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [8:0] press = '0;
    logic [8:0] board = 9'h1FF;
    logic [8:0] rand_in = '0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid, cmd_op, win, lost;
    logic [3:0] cmd_idx;
    logic [8:0] cmd_data;
    logic [2:0] state;
    logic [7:0] moves;

    int total = 0;
    int bad = 0;

    logic [8:0] out;
    int         m_moves;
    logic       prev_valid;
    logic [3:0] exp_idx;

    always #5 CLK = ~CLK;

    lightsout_game_ctrl #(.WIN_HOLD(HOLD), .MOVE_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .press(press), .board(board), .rand_in(rand_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .cmd_data(cmd_data), .state(state), .moves(moves), .win(win), .lost(lost)
    );

`ifdef LIGHTSOUT_MOVE_LIMIT_EN
    logic       l_cmd_valid, l_cmd_op, l_win, l_lost;
    logic [3:0] l_cmd_idx;
    logic [8:0] l_cmd_data;
    logic [2:0] l_state;
    logic [7:0] l_moves;

    lightsout_game_ctrl #(.WIN_HOLD(HOLD), .MOVE_W(8), .MOVE_LIMIT(3)) dut_lim (
        .CLK(CLK), .RESET_N(RESET_N), .press(press), .board(board), .rand_in(rand_in),
        .cmd_valid(l_cmd_valid), .cmd_ready(cmd_ready), .cmd_op(l_cmd_op), .cmd_idx(l_cmd_idx),
        .cmd_data(l_cmd_data), .state(l_state), .moves(l_moves), .win(l_win), .lost(l_lost)
    );
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [8:0] s);
        for (int i = 0; i < 9; i++)
            if (s[i]) return 4'(i);
        return 4'hF;
    endfunction

    // One cycle of play checked against the outstanding-press scoreboard
    task automatic rcycle(input logic [8:0] p, input logic r);
        logic acc;
        press = p;
        cmd_ready = r;
        if (cmd_valid && !prev_valid) begin
            exp_idx = lowest(out);
            chk("rnd_issue_idx", 32'(cmd_idx), 32'(exp_idx));
        end else if (cmd_valid) begin
            chk("rnd_hold_idx", 32'(cmd_idx), 32'(exp_idx));
        end
        acc = cmd_valid && r;
        out = acc ? ((out & ~(9'h001 << exp_idx)) | p) : (out | p);
        if (acc) m_moves++;
        prev_valid = cmd_valid;
        tick();
        press = '0;
        if (acc) chk("rnd_moves", 32'(moves), 32'(m_moves));
    endtask

    initial begin
        int n;
        // reset state
        tick(); tick();
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_op", 32'(cmd_op), 0);
        chk("rst_idx", 32'(cmd_idx), 0);
        chk("rst_data", 32'(cmd_data), 0);
        chk("rst_moves", 32'(moves), 0);
        chk("rst_win", 32'(win), 0);
        chk("rst_lost", 32'(lost), 0);
        RESET_N = 1'b1;
        tick();

        // seed with captured random value
        press = 9'h004; rand_in = 9'h0A5; tick(); press = '0; rand_in = 9'h033;
        chk("seed_state", 32'(state), 32'(ST_SEED));
        chk("seed_valid", 32'(cmd_valid), 1);
        chk("seed_op", 32'(cmd_op), 1);
        chk("seed_data", 32'(cmd_data), 32'h0A5);
        tick();
        chk("seed_data_hold", 32'(cmd_data), 32'h0A5);
        cmd_ready = 1'b1; tick();
        chk("seed_play", 32'(state), 32'(ST_PLAY));
        chk("seed_moves", 32'(moves), 0);
        chk("seed_valid_drop", 32'(cmd_valid), 0);

        // two presses in one cycle -> two toggles, lowest first
        press = 9'h120; tick(); press = '0;
        chk("t1_valid", 32'(cmd_valid), 1);
        chk("t1_op", 32'(cmd_op), 0);
        chk("t1_idx", 32'(cmd_idx), 5);
        tick();
        chk("t1_wait", 32'(state), 32'(ST_WAIT));
        chk("t1_wait_valid", 32'(cmd_valid), 0);
        chk("t1_moves", 32'(moves), 1);
        tick();
        chk("t1_play", 32'(state), 32'(ST_PLAY));
        tick();
        chk("t2_valid", 32'(cmd_valid), 1);
        chk("t2_idx", 32'(cmd_idx), 8);
        tick(); tick();
        chk("t2_moves", 32'(moves), 2);

        // back-pressure: command holds while a lower press arrives
        cmd_ready = 1'b0;
        press = 9'h004; tick(); press = 9'h001;
        for (int i = 0; i < 5; i++) begin
            tick(); press = '0;
            chk("bp_valid", 32'(cmd_valid), 1);
            chk("bp_idx", 32'(cmd_idx), 2);
        end
        cmd_ready = 1'b1; tick(); tick(); tick();
        chk("bp_next_idx", 32'(cmd_idx), 0);
        tick(); tick();
        chk("bp_moves", 32'(moves), 4);

        // same-bit press at accept keeps the bit pending
        press = 9'h002; tick();
        chk("rep_idx", 32'(cmd_idx), 1);
        tick(); press = '0;
        chk("rep_moves", 32'(moves), 5);
        tick(); tick();
        chk("rep_valid", 32'(cmd_valid), 1);
        chk("rep_idx2", 32'(cmd_idx), 1);

        // win: board dark after accept
        board = '0; tick(); tick();
        chk("win_state", 32'(state), 32'(ST_WIN));
        chk("win_flag", 32'(win), 1);
        chk("win_valid", 32'(cmd_valid), 0);
        n = 0;
        while (win && n < 100) begin
            press = 9'($urandom); tick(); n++;
        end
        press = '0; board = 9'h1FF;
        chk("win_hold", n, HOLD);
        chk("win_idle", 32'(state), 32'(ST_IDLE));
        tick(); tick();
        chk("win_ignored", 32'(cmd_valid), 0);

        // zero random seed falls back
        rand_in = '0; press = 9'h100; tick(); press = '0;
        chk("fb_data", 32'(cmd_data), 32'h010);
        chk("fb_moves", 32'(moves), 0);
        tick(); tick();
        chk("fb_no_pending", 32'(cmd_valid), 0);

        // reset mid-handshake
        cmd_ready = 1'b0; press = 9'h008; tick(); press = '0;
        chk("mr_idx", 32'(cmd_idx), 3);
        RESET_N = 1'b0; tick();
        chk("mr_valid", 32'(cmd_valid), 0);
        chk("mr_state", 32'(state), 32'(ST_IDLE));
        chk("mr_idx0", 32'(cmd_idx), 0);
        RESET_N = 1'b1; cmd_ready = 1'b1; tick(); tick();
        chk("mr_stays_idle", 32'(state), 32'(ST_IDLE));

        // three toggles on a lit board
        rand_in = 9'h055; press = 9'h001; tick(); press = '0; tick();
        for (int k = 0; k < 3; k++) begin
            press = 9'h001 << k; tick(); press = '0; tick(); tick();
        end
        chk("ml_main_state", 32'(state), 32'(ST_PLAY));
        chk("ml_main_moves", 32'(moves), 3);
        chk("ml_main_lost", 32'(lost), 0);
`ifdef LIGHTSOUT_MOVE_LIMIT_EN
        chk("ml_lim_state", 32'(l_state), 32'(ST_IDLE));
        chk("ml_lim_lost", 32'(l_lost), 1);
        press = 9'h010; tick(); press = '0;
        chk("ml_lim_clear", 32'(l_lost), 0);
        chk("ml_lim_seed", 32'(l_state), 32'(ST_SEED));
`endif
        RESET_N = 1'b0; tick(); RESET_N = 1'b1; tick();

        // randomized play against the scoreboard
        rand_in = 9'($urandom); press = 9'h001; tick(); press = '0; tick();
        chk("rnd_start", 32'(state), 32'(ST_PLAY));
        out = '0; m_moves = 0; prev_valid = 1'b0; exp_idx = '0;
        for (int c = 0; c < 100; c++)
            rcycle(($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h000, 1'($urandom_range(0, 1)));
        for (int c = 0; c < 80 && (out != '0 || cmd_valid || state != 3'(ST_PLAY)); c++)
            rcycle('0, 1'b1);
        chk("rnd_drained", 32'(out), 0);
        chk("rnd_final_moves", 32'(moves), 32'(m_moves));
        tick(); tick();
        chk("rnd_quiet", 32'(cmd_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lightsout_game_ctrl.md
LIGHTSOUT_GAME_CTRL -- requirements
Module: lightsout_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_HOLD, default 1024: cycles the WIN state is held before returning to IDLE.
REQ-002 SHALL have parameter MOVE_W, default 8: width of the move counter.
REQ-003 SHALL have port CLK  input  1  clock; all logic on posedge.
REQ-004 SHALL have port RESET_N  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port press  input  9  single-cycle debounced press pulses, bit i = cell i, row-major.
REQ-006 SHALL have port board  input  9  current board state from the datapath; 0 means all lights out.
REQ-007 SHALL have port rand_in  input  9  free-running random value from the datapath LFSR.
REQ-008 SHALL have port cmd_valid  output  1  command to the board datapath is valid.
REQ-009 SHALL have port cmd_ready  input  1  datapath accepts the command this cycle.
REQ-010 SHALL have port cmd_op  output  1  0 = TOGGLE cell cmd_idx, 1 = LOAD cmd_data.
REQ-011 SHALL have port cmd_idx  output  4  cell index 0..8 for TOGGLE.
REQ-012 SHALL have port cmd_data  output  9  board pattern for LOAD.
REQ-013 SHALL have port state  output  3  encoded FSM state.
REQ-014 SHALL have port moves  output  MOVE_W  accepted toggles in the current game.
REQ-015 SHALL have port win  output  1  high while in WIN.
REQ-016 SHALL have port lost  output  1  high while the lost flag is set.

Function
REQ-017 SHALL implement states IDLE, SEED, PLAY, WAIT, WIN.
REQ-018 IDLE: any press bit -> SEED; pending cleared; moves cleared; lost cleared.
REQ-019 SEED: cmd_valid=1, cmd_op=1, cmd_data = rand_in captured on IDLE exit, or 9'h010 if the captured value is 0; on accept -> PLAY.
REQ-020 SHALL OR every press pulse into a 9-bit pending register in PLAY, WAIT and SEED; presses in IDLE and WIN are not recorded.
REQ-021 PLAY: if any pending bit is set, issue TOGGLE with cmd_idx = lowest set pending index.
REQ-022 While cmd_valid=1 and cmd_ready=0, cmd_op, cmd_idx and cmd_data SHALL hold stable, even if new presses arrive.
REQ-023 On TOGGLE accept: clear that pending bit, unless a press for the same bit arrives that cycle (bit stays set); moves += 1, saturating at all-ones; -> WAIT.
REQ-024 WAIT: exactly one cycle, cmd_valid=0; board==0 -> WIN, else -> PLAY.
REQ-025 WIN: cmd_valid=0; pending cleared every cycle; after WIN_HOLD cycles -> IDLE.
REQ-026 TOGGLE issue latency SHALL be 1 cycle: a press at cycle n, with PLAY and no other pending, gives cmd_valid at n+1.
REQ-027 cmd_valid SHALL be 0 in IDLE, WAIT and WIN.

Reset
REQ-028 RESET_N=0 SHALL force state=IDLE, pending=0, moves=0, cmd_valid=0, cmd_op=0, cmd_idx=0, cmd_data=0, win=0, lost=0 and the WIN timer to 0.
REQ-029 Reset asserted mid-handshake SHALL drop the outstanding command without completing it.

Configuration
REQ-030 Macro LIGHTSOUT_MOVE_LIMIT_EN defined: parameter MOVE_LIMIT (default 50) SHALL be compiled in.
REQ-031 With LIGHTSOUT_MOVE_LIMIT_EN, in WAIT, board!=0 and moves==MOVE_LIMIT SHALL go to IDLE and set lost.
REQ-032 With LIGHTSOUT_MOVE_LIMIT_EN, lost SHALL clear on the next IDLE exit.
REQ-033 Without LIGHTSOUT_MOVE_LIMIT_EN, lost SHALL be tied to 0 and there SHALL be no move limit.

Structure
REQ-034 Package lightsout_pkg SHALL hold the state encoding, the cmd_op codes, the 9'h010 fallback seed and the cell count 9.
REQ-035 Sub-module lightsout_prio_arb SHALL perform the 9-bit lowest-index-first selection: pending in; grant index and any-valid out; combinational.

Verification
REQ-036 Reset, then press=9'h004 with rand_in=9'h0A5 -> SEED command op=1, data=9'h0A5; accept -> PLAY, moves=0.
REQ-037 IDLE exit with rand_in=0 -> LOAD data=9'h010.
REQ-038 PLAY, press=9'h120 in one cycle, cmd_ready=1 -> TOGGLE idx 5, then idx 8 on separate commands; moves=2.
REQ-039 cmd_ready held 0 for 5 cycles while press=9'h001 arrives -> cmd_idx stays at the original index until accept.
REQ-040 Accept TOGGLE with board=0 in WAIT -> win=1 for exactly WIN_HOLD cycles, then IDLE; presses during WIN ignored.
REQ-041 With LIGHTSOUT_MOVE_LIMIT_EN and MOVE_LIMIT=3: three accepts with board!=0 -> IDLE with lost=1; next press clears lost.
